cpu_dma_queue_stats_regs: RTL and testbench
===========================================

// Module: cpu_dma_queue_stats_regs
// PURPOSE
//   Per-queue statistics register block for the CPU DMA queues. It has NUM_QUEUES
//   queues with four event counters each (tx_timeout, tx_pkt, rx_pkt, rx_drop), and
//   each counter is optionally saturating. Software has read, write-to-preset,
//   global clear and clear-on-read access through the MAC-group register bus.
//   The block sits beside the CPU DMA queue datapath, which drives the 1-cycle
//   event pulses.
// PARAMETERS
//   NUM_QUEUES       4   queues served, 1..16
//   CNT_WIDTH        32  counter width, 1..32; read data is zero-extended to 32 bits
//   REG_ADDR_WIDTH   8   reg_addr width; needs 4*NUM_QUEUES < 2**REG_ADDR_WIDTH-1
//   SATURATE         1   1: counters hold at 2**CNT_WIDTH-1. 0: counters wrap to 0
//   CLR_ON_RD_DFLT   0   reset value of the clear-on-read control bit
// PORTS
//   clk           in   1               system clock
//   reset         in   1               asynchronous, active-low reset (0 = in reset)
//   tx_timeout    in   NUM_QUEUES      per-queue event pulse, 1 cycle each
//   tx_pkt        in   NUM_QUEUES      per-queue event pulse
//   rx_pkt        in   NUM_QUEUES      per-queue event pulse
//   rx_drop       in   NUM_QUEUES      per-queue event pulse
//   reg_req       in   1               request; level-held until reg_ack
//   reg_rd_wr_L   in   1               1 = read, 0 = write
//   reg_addr      in   REG_ADDR_WIDTH  word address
//   reg_wr_data   in   32              write data
//   reg_rd_data   out  32              read data, valid while reg_ack=1 and held after
//   reg_ack       out  1               one-cycle completion pulse
// BEHAVIOUR
//   Address map: addr = 4*q + c for q < NUM_QUEUES.
//     c = 0 tx_timeout, 1 tx_pkt, 2 rx_pkt, 3 rx_drop.
//     CTRL is at addr = all ones.
//     CTRL read: [31:16] = NUM_QUEUES, [1] = clr_on_rd, all other bits 0.
//     CTRL write: [0] = 1 clears every counter (self-clearing), [1] -> clr_on_rd.
//     Any other address is bad: a read returns 32'hdead_beef, a write is ignored,
//     and both are still acked.
//   Reset (asynchronous, reset = 0):
//     all counters = 0, reg_rd_data = 0, reg_ack = 0, clr_on_rd = CLR_ON_RD_DFLT.
//     reg_req_d1 = 1, so a request still held across reset release is not served.
//     Reset mid-transaction aborts the request with no ack.
//   Handshake:
//     new_req = reg_req & ~reg_req_d1 (rising edge), sampled at cycle N.
//     reg_ack = 1 for exactly cycle N+1; reg_rd_data updates at the same edge.
//     Read data is the counter value at cycle N, before any update in cycle N.
//     Holding reg_req high produces no further acks.
//   Counter next-value, highest priority first:
//     1. CTRL clear-all write: next = 0. An event in the same cycle is dropped.
//     2. Write to this counter: next = wr_data[CNT_WIDTH-1:0] + event.
//     3. Read with clr_on_rd = 1: next = event (0 or 1). The event is not lost.
//     4. Otherwise: next = cnt + event.
//   Increment rule: with SATURATE=1, cnt = max stays at max; with SATURATE=0, max wraps to 0.
//   All 4*NUM_QUEUES counters update independently in the same cycle.
//   Event-to-visible latency is 1 cycle: a pulse at N is readable from a request at N+1.
// TESTING
//   1. Reset release, read q0 c0 and CTRL (CLR_ON_RD_DFLT=0).
//      -> ack 1 cycle later, data 0; CTRL reads 32'h0004_0000.
//   2. 5 tx_pkt pulses on q2, then read addr 9.
//      -> reads 5, and a repeat read still reads 5.
//   3. Write CTRL = 2 (clr_on_rd on), then 3 rx_drop pulses on q1.
//      -> first read of addr 7 = 3. A read coinciding with 1 more pulse = 0.
//      -> the next read = 1.
//   4. CNT_WIDTH=4: 17 pulses with SATURATE=1 -> reads 15.
//      -> the same with SATURATE=0 reads 1.
//   5. Write 32'h10 to addr 0 in the same cycle as a tx_timeout[0] pulse -> reads 17.
//      -> write CTRL = 1 -> all counters read 0.
//   6. Read addr 8'hf0 -> 32'hdead_beef with ack.
//      -> pull reset low while reg_req is high: ack=0, and no ack after release
//         until reg_req toggles.

Source files
------------

// File: rtl/cpu_dma_queue_stats_regs.sv
// Per-queue CPU DMA statistics counters (tx_timeout, tx_pkt, rx_pkt, rx_drop) with
// register-bus read, preset write, global clear and clear-on-read.
module cpu_dma_queue_stats_regs #(
  parameter int unsigned NUM_QUEUES     = 4,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned REG_ADDR_WIDTH = 8,
  parameter bit          SATURATE       = 1'b1,
  parameter bit          CLR_ON_RD_DFLT = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_QUEUES-1:0]     tx_timeout,
  input  logic [NUM_QUEUES-1:0]     tx_pkt,
  input  logic [NUM_QUEUES-1:0]     rx_pkt,
  input  logic [NUM_QUEUES-1:0]     rx_drop,
  input  logic                      reg_req,
  input  logic                      reg_rd_wr_L,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
  input  logic [31:0]               reg_wr_data,
  output logic [31:0]               reg_rd_data,
  output logic                      reg_ack
);

  localparam int unsigned NUM_CNT = 4 * NUM_QUEUES;
  localparam logic [REG_ADDR_WIDTH-1:0] CTRL_ADDR  = '1;
  localparam logic [REG_ADDR_WIDTH-1:0] NUM_CNT_A  = REG_ADDR_WIDTH'(NUM_CNT);
  localparam logic [31:0]               BAD_RDATA  = 32'hdead_beef;

  logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CNT];
  logic [31:0]          reg_rd_data_q, reg_rd_data_d;
  logic                 reg_ack_q, reg_ack_d;
  logic                 reg_req_d1_q, reg_req_d1_d;
  logic                 clr_on_rd_q, clr_on_rd_d;

  logic [NUM_CNT-1:0]   ev;
  logic                 new_req, rd_req, wr_req;
  logic                 is_ctrl, is_cnt, clr_all;
  logic [31:0]          cnt_rdata;

  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] base,
                                                 input logic               inc);
    logic [CNT_WIDTH-1:0] r;
    r = base;
    if (inc) begin
      if (SATURATE && (base == '1)) r = base;
      else                          r = base + CNT_WIDTH'(1);
    end
    return r;
  endfunction

  // Flatten events into address order: index 4*q + c.
  always_comb begin
    ev = '0;
    for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
      ev[4*q + 0] = tx_timeout[q];
      ev[4*q + 1] = tx_pkt[q];
      ev[4*q + 2] = rx_pkt[q];
      ev[4*q + 3] = rx_drop[q];
    end
  end

  always_comb begin
    new_req = reg_req & ~reg_req_d1_q;
    rd_req  = new_req & reg_rd_wr_L;
    wr_req  = new_req & ~reg_rd_wr_L;
    is_ctrl = (reg_addr == CTRL_ADDR);
    is_cnt  = (reg_addr < NUM_CNT_A);
    clr_all = wr_req & is_ctrl & reg_wr_data[0];
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = bump(cnt_q[i], ev[i]);
      if (clr_all) begin
        cnt_d[i] = '0;
      end else if (wr_req && is_cnt && (reg_addr == REG_ADDR_WIDTH'(i))) begin
        cnt_d[i] = bump(reg_wr_data[CNT_WIDTH-1:0], ev[i]);
      end else if (rd_req && clr_on_rd_q && is_cnt && (reg_addr == REG_ADDR_WIDTH'(i))) begin
        cnt_d[i] = CNT_WIDTH'(ev[i]);
      end
    end
  end

  always_comb begin
    cnt_rdata = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (reg_addr == REG_ADDR_WIDTH'(i)) cnt_rdata[CNT_WIDTH-1:0] = cnt_q[i];
    end
  end

  // Read data is captured from pre-update counter values; writes leave it unchanged.
  always_comb begin
    reg_req_d1_d  = reg_req;
    reg_ack_d     = new_req;
    reg_rd_data_d = reg_rd_data_q;
    clr_on_rd_d   = clr_on_rd_q;
    if (rd_req) begin
      if (is_cnt)       reg_rd_data_d = cnt_rdata;
      else if (is_ctrl) reg_rd_data_d = {16'(NUM_QUEUES), 14'b0, clr_on_rd_q, 1'b0};
      else              reg_rd_data_d = BAD_RDATA;
    end
    if (wr_req && is_ctrl) clr_on_rd_d = reg_wr_data[1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
      reg_rd_data_q <= '0;
      reg_ack_q     <= 1'b0;
      reg_req_d1_q  <= 1'b1;
      clr_on_rd_q   <= CLR_ON_RD_DFLT;
    end else begin
      for (int unsigned i = 0; i < NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
      reg_rd_data_q <= reg_rd_data_d;
      reg_ack_q     <= reg_ack_d;
      reg_req_d1_q  <= reg_req_d1_d;
      clr_on_rd_q   <= clr_on_rd_d;
    end
  end

  assign reg_rd_data = reg_rd_data_q;
  assign reg_ack     = reg_ack_q;

endmodule

// File: tb/tb_cpu_dma_queue_stats_regs.sv
// Directed bench for cpu_dma_queue_stats_regs: vector table plus hand-written
// saturation/wrap and reset-abort sequences.
module tb_cpu_dma_queue_stats_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  tx_timeout, tx_pkt, rx_pkt, rx_drop;
  logic [3:0]  ev4;
  logic [3:0]  zero4;
  logic        reg_req, reg_rd_wr_L;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wr_data;
  logic [31:0] rd_data, rd_data_s, rd_data_w;
  logic        ack, ack_s, ack_w;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  cpu_dma_queue_stats_regs dut (
    .clk(clk), .reset(rst_n),
    .tx_timeout(tx_timeout), .tx_pkt(tx_pkt), .rx_pkt(rx_pkt), .rx_drop(rx_drop),
    .reg_req(reg_req), .reg_rd_wr_L(reg_rd_wr_L), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_rd_data(rd_data), .reg_ack(ack)
  );

  cpu_dma_queue_stats_regs #(.CNT_WIDTH(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(rst_n),
    .tx_timeout(zero4), .tx_pkt(ev4), .rx_pkt(zero4), .rx_drop(zero4),
    .reg_req(reg_req), .reg_rd_wr_L(reg_rd_wr_L), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_rd_data(rd_data_s), .reg_ack(ack_s)
  );

  cpu_dma_queue_stats_regs #(.CNT_WIDTH(4), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(rst_n),
    .tx_timeout(zero4), .tx_pkt(ev4), .rx_pkt(zero4), .rx_drop(zero4),
    .reg_req(reg_req), .reg_rd_wr_L(reg_rd_wr_L), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_rd_data(rd_data_w), .reg_ack(ack_w)
  );

  typedef struct {
    bit          rd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int unsigned ev_sel;   // 0 tx_timeout, 1 tx_pkt, 2 rx_pkt, 3 rx_drop
    logic [3:0]  ev_mask;
    int unsigned n_pre;    // event cycles before the request
    bit          ev_with;  // event also in the request cycle
    bit          chk_data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rd, input logic [7:0] addr, input logic [31:0] wdata,
                     input int unsigned sel, input logic [3:0] mask, input int unsigned n_pre,
                     input bit ev_with, input bit chk_data, input logic [31:0] exp);
    vec_t v;
    v.rd = rd; v.addr = addr; v.wdata = wdata; v.ev_sel = sel; v.ev_mask = mask;
    v.n_pre = n_pre; v.ev_with = ev_with; v.chk_data = chk_data; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_ev(input int unsigned sel, input logic [3:0] mask);
    case (sel)
      0: tx_timeout = mask;
      1: tx_pkt     = mask;
      2: rx_pkt     = mask;
      default: rx_drop = mask;
    endcase
  endtask

  task automatic clr_ev();
    tx_timeout = '0; tx_pkt = '0; rx_pkt = '0; rx_drop = '0; ev4 = '0;
  endtask

  // All tasks start and end just after a falling edge.
  task automatic pulses(input int unsigned sel, input logic [3:0] mask, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      set_ev(sel, mask);
      @(negedge clk);
    end
    clr_ev();
  endtask

  task automatic txn(input string name, input bit rd, input logic [7:0] addr,
                     input logic [31:0] wdata, input int unsigned sel,
                     input logic [3:0] mask, input bit ev_with,
                     output logic [31:0] data);
    reg_req = 1'b1; reg_rd_wr_L = rd; reg_addr = addr; reg_wr_data = wdata;
    if (ev_with) set_ev(sel, mask);
    @(posedge clk); #1;
    chk({name, "_ack"}, {31'b0, ack}, 32'd1);
    data = rd_data;
    @(negedge clk);
    clr_ev();
    reg_req = 1'b0;
    @(negedge clk);
    chk({name, "_ack_end"}, {31'b0, ack}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    rst_n = 1'b0; zero4 = '0; clr_ev();
    reg_req = 1'b0; reg_rd_wr_L = 1'b1; reg_addr = '0; reg_wr_data = '0;

    // test 1
    add(1, 8'h00, 0, 0, 4'h0, 0, 0, 1, 32'h0);
    add(1, 8'hff, 0, 0, 4'h0, 0, 0, 1, 32'h0004_0000);
    // test 2
    add(1, 8'h09, 0, 1, 4'b0100, 5, 0, 1, 32'd5);
    add(1, 8'h09, 0, 1, 4'b0100, 0, 0, 1, 32'd5);
    // test 3: clear-on-read
    add(0, 8'hff, 32'h2, 0, 4'h0, 0, 0, 0, 32'h0);
    add(1, 8'hff, 0, 0, 4'h0, 0, 0, 1, 32'h0004_0002);
    add(1, 8'h07, 0, 3, 4'b0010, 3, 0, 1, 32'd3);
    add(1, 8'h07, 0, 3, 4'b0010, 0, 1, 1, 32'd0);
    add(1, 8'h07, 0, 3, 4'b0010, 0, 0, 1, 32'd1);
    add(0, 8'hff, 32'h0, 0, 4'h0, 0, 0, 0, 32'h0);
    // test 5: preset write with coincident event, then clear-all
    add(0, 8'h00, 32'h10, 0, 4'b0001, 0, 1, 0, 32'h0);
    add(1, 8'h00, 0, 0, 4'h0, 0, 0, 1, 32'd17);
    add(1, 8'h09, 0, 0, 4'h0, 0, 0, 1, 32'd5);
    add(0, 8'hff, 32'h1, 0, 4'h0, 0, 0, 0, 32'h0);
    add(1, 8'h00, 0, 0, 4'h0, 0, 0, 1, 32'd0);
    add(1, 8'h09, 0, 0, 4'h0, 0, 0, 1, 32'd0);
    add(1, 8'hff, 0, 0, 4'h0, 0, 0, 1, 32'h0004_0000);
    // clear-all drops a coincident event
    add(1, 8'h0e, 0, 2, 4'b1000, 2, 0, 1, 32'd2);
    add(0, 8'hff, 32'h1, 2, 4'b1000, 0, 1, 0, 32'h0);
    add(1, 8'h0e, 0, 0, 4'h0, 0, 0, 1, 32'd0);
    // test 6: bad addresses
    add(1, 8'hf0, 0, 0, 4'h0, 0, 0, 1, 32'hdead_beef);
    add(0, 8'h10, 32'h5, 0, 4'h0, 0, 0, 0, 32'h0);
    add(1, 8'h10, 0, 0, 4'h0, 0, 0, 1, 32'hdead_beef);

    repeat (3) @(negedge clk);
    chk("reset_ack", {31'b0, ack}, 32'd0);
    chk("reset_rdata", rd_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      pulses(vecs[i].ev_sel, vecs[i].ev_mask, vecs[i].n_pre);
      txn($sformatf("v%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].wdata,
          vecs[i].ev_sel, vecs[i].ev_mask, vecs[i].ev_with, d);
      if (vecs[i].chk_data) chk($sformatf("v%0d_data", i), d, vecs[i].exp);
    end

    // 17 tx_pkt pulses on q0 of the 4-bit instances
    for (int unsigned k = 0; k < 17; k++) begin
      ev4 = 4'b0001;
      @(negedge clk);
    end
    clr_ev();
    txn("sat_rd", 1, 8'h01, 0, 0, 4'h0, 0, d);
    chk("sat_main_q0_txpkt", d, 32'd0);
    chk("sat_4bit", rd_data_s, 32'd15);
    chk("wrap_4bit", rd_data_w, 32'd1);

    // reset mid-transaction with the request still held across release
    txn("pre_rst_ctrl", 0, 8'hff, 32'h2, 0, 4'h0, 0, d);
    pulses(1, 4'b0001, 4);
    reg_req = 1'b1; reg_rd_wr_L = 1'b1; reg_addr = 8'h01;
    @(posedge clk); #1;
    chk("rst_txn_ack", {31'b0, ack}, 32'd1);
    chk("rst_txn_data", rd_data, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_abort_ack", {31'b0, ack}, 32'd0);
    chk("rst_abort_rdata", rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("held_req_no_ack%0d", k), {31'b0, ack}, 32'd0);
    end
    reg_req = 1'b0;
    @(negedge clk);
    txn("post_rst_cnt", 1, 8'h01, 0, 0, 4'h0, 0, d);
    chk("post_rst_cnt_data", d, 32'd0);
    txn("post_rst_ctrl", 1, 8'hff, 0, 0, 4'h0, 0, d);
    chk("post_rst_ctrl_data", d, 32'h0004_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
